// File: rtl/iter_addsub_feeder.sv
// ============================================================================
//  Module      : iter_addsub_feeder
//  Description : Parallel-to-serial operand feeder for a bit-serial add/sub
//                stage. Streams A, B and the op select LSB-first, one bit per
//                clock, with first/last framing and back-to-back operation.
//                Optional macro SERIAL_GUARD_BIT_EN appends one sign-extension
//                bit per operation (WIDTH+1 serial bits).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iter_addsub_feeder #(
    parameter  int WIDTH = 16,
    localparam int IDX_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             abort,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_sub,
    output logic             ser_first,
    output logic             ser_last,
    output logic             ser_valid,
    output logic [IDX_W-1:0] ser_idx
);

`ifdef SERIAL_GUARD_BIT_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   sh_a_q;
    logic [WIDTH-1:0]   sh_b_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               ser_a_q;
    logic               ser_b_q;
    logic               ser_sub_q;
    logic               ser_first_q;
    logic               ser_last_q;
    logic               ser_valid_q;
    logic               w_accept;

    // Ready only while idle or on the final bit, never under abort or reset.
    assign in_ready = aclr_n & ~abort & ((state_q == S_IDLE) | ser_last_q);
    assign w_accept = in_valid & in_ready;
    assign idx_d    = idx_q + IDX_W'(1);

    // The shift registers hold the bits still to be presented; shifting is
    // arithmetic so the guard bit (if enabled) replicates the operand MSB.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q     <= S_IDLE;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            idx_q       <= '0;
            ser_a_q     <= 1'b0;
            ser_b_q     <= 1'b0;
            ser_sub_q   <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            ser_valid_q <= 1'b0;
        end else if (!abort && w_accept) begin
            state_q     <= S_SHIFT;
            sh_a_q      <= {in_a[WIDTH-1], in_a[WIDTH-1:1]};
            sh_b_q      <= {in_b[WIDTH-1], in_b[WIDTH-1:1]};
            idx_q       <= '0;
            ser_a_q     <= in_a[0];
            ser_b_q     <= in_b[0];
            ser_sub_q   <= in_sub;
            ser_first_q <= 1'b1;
            ser_last_q  <= 1'b0;
            ser_valid_q <= 1'b1;
        end else if (!abort && state_q == S_SHIFT && !ser_last_q) begin
            sh_a_q      <= {sh_a_q[WIDTH-1], sh_a_q[WIDTH-1:1]};
            sh_b_q      <= {sh_b_q[WIDTH-1], sh_b_q[WIDTH-1:1]};
            idx_q       <= idx_d;
            ser_a_q     <= sh_a_q[0];
            ser_b_q     <= sh_b_q[0];
            ser_first_q <= 1'b0;
            ser_last_q  <= (idx_d == LAST_IDX);
        end else begin
            state_q     <= S_IDLE;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            idx_q       <= '0;
            ser_a_q     <= 1'b0;
            ser_b_q     <= 1'b0;
            ser_sub_q   <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            ser_valid_q <= 1'b0;
        end
    end

    assign ser_a     = ser_a_q;
    assign ser_b     = ser_b_q;
    assign ser_sub   = ser_sub_q;
    assign ser_first = ser_first_q;
    assign ser_last  = ser_last_q;
    assign ser_valid = ser_valid_q;
    assign ser_idx   = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_iter_addsub_feeder.sv
// ============================================================================
//  Module      : tb_iter_addsub_feeder
//  Description : Scoreboard bench for iter_addsub_feeder (WIDTH=8) with a
//                behavioural serial adder collecting the sum LSB-first.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iter_addsub_feeder;

    localparam int W = 8;
`ifdef SERIAL_GUARD_BIT_EN
    localparam int NB = W + 1;
    localparam logic [8:0] SMASK = 9'h1FF;
`else
    localparam int NB = W;
    localparam logic [8:0] SMASK = 9'h0FF;
`endif

    logic       clk = 1'b0;
    logic       aclr_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic       in_sub = 1'b0;
    logic       abort = 1'b0;
    logic       ser_a, ser_b, ser_sub, ser_first, ser_last, ser_valid;
    logic [3:0] ser_idx;

    iter_addsub_feeder #(.WIDTH(W)) dut (
        .clk(clk), .aclr_n(aclr_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .abort(abort),
        .ser_a(ser_a), .ser_b(ser_b), .ser_sub(ser_sub), .ser_first(ser_first),
        .ser_last(ser_last), .ser_valid(ser_valid), .ser_idx(ser_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        logic       sub;
        logic [8:0] sum;
        int         acc_cyc;
    } item_t;

    item_t      sb[$];
    item_t      cur;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         bit_i = 0;
    int         n_valid = 0;
    int         prev_last_cyc = 0;
    int         b2b_seen = 0;
    bit         active = 1'b0;
    bit         flush_ok = 1'b0;
    bit         b2b_mode = 1'b0;
    logic       carry = 1'b0;
    logic       bb;
    logic [8:0] acc = '0;
    logic [8:0] last_sum = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: behavioural serial adder, carry reseeded with sub on the first bit.
    always @(negedge clk) begin
        if (!b2b_mode) b2b_seen = 0;
        if (ser_valid) begin
            n_valid++;
            if (ser_first) begin
                check("overlap", 32'(active), 0);
                if (sb.size() == 0) begin
                    check("unexpected_op", 1, 0);
                    active = 1'b0;
                end else begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                    bit_i  = 0;
                    carry  = cur.sub;
                    acc    = '0;
                    check("latency", 32'(cyc), 32'(cur.acc_cyc));
                    if (b2b_mode) begin
                        if (b2b_seen > 0) check("b2b_gap", 32'(cyc - prev_last_cyc), 1);
                        b2b_seen++;
                    end
                end
            end else if (!active) begin
                check("stray_valid", 1, 0);
            end
            if (active) begin
                check("idx", 32'(ser_idx), 32'(bit_i));
                check("ser_a", 32'(ser_a), 32'(cur.a[bit_i]));
                check("ser_b", 32'(ser_b), 32'(cur.b[bit_i]));
                check("ser_sub", 32'(ser_sub), 32'(cur.sub));
                check("first", 32'(ser_first), 32'(bit_i == 0));
                check("last", 32'(ser_last), 32'(bit_i == NB - 1));
                bb         = ser_b ^ ser_sub;
                acc[bit_i] = ser_a ^ bb ^ carry;
                carry      = (ser_a & bb) | (ser_a & carry) | (bb & carry);
                if (bit_i == NB - 1) begin
                    check("sum", 32'(acc), 32'(cur.sum));
                    last_sum      = acc;
                    prev_last_cyc = cyc;
                    active        = 1'b0;
                end
                bit_i++;
            end
        end else if (active) begin
            if (!flush_ok) check("truncated", 32'(bit_i), 32'(NB));
            active = 1'b0;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s);
        item_t it;
        int    n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_sub   = s;
        #1;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            it.a       = {a[7], a};
            it.b       = {b[7], b};
            it.sub     = s;
            it.sum     = (s ? (it.a - it.b) : (it.a + it.b)) & SMASK;
            it.acc_cyc = cyc + 1;
            sb.push_back(it);
            @(negedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        #1;
        while ((sb.size() != 0 || active) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", 32'(sb.size() == 0 && !active), 1);
        @(negedge clk);
    endtask

    task automatic wait_idx(input int k);
        int n = 0;
        #1;
        while (32'(ser_idx) != k && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reach_idx", 32'(ser_idx), 32'(k));
    endtask

    initial begin
        int v0;
        #2;
        check("rst_outs", 32'({ser_valid, ser_first, ser_last, ser_a, ser_b, ser_sub, ser_idx}), 0);
        check("rst_ready", 32'(in_ready), 0);
        #11 aclr_n = 1'b1;
        #1 check("rel_ready", 32'(in_ready), 1);
        @(negedge clk);

        // Basic add, then idle after last bit
        send(8'h35, 8'h0F, 1'b0);
        in_valid = 1'b0;
        wait_done();
        check("t1_sum", 32'(last_sum), 32'h044);
        check("idle_outs", 32'({ser_valid, ser_first, ser_last, ser_a, ser_b, ser_sub, ser_idx}), 0);

        // Subtractions
        send(8'h10, 8'h01, 1'b1);
        in_valid = 1'b0;
        wait_done();
        check("t2a_sum", 32'(last_sum), 32'h00F);
        send(8'h00, 8'h01, 1'b1);
        in_valid = 1'b0;
        wait_done();
        check("t2b_sum", 32'(last_sum), 32'(SMASK));

        // Back-to-back with in_valid held
        b2b_mode = 1'b1;
        v0 = n_valid;
        send(8'h12, 8'h34, 1'b0);
        send(8'h80, 8'h7F, 1'b1);
        send(8'hA5, 8'h5A, 1'b0);
        in_valid = 1'b0;
        wait_done();
        check("b2b_count", 32'(n_valid - v0), 32'(3 * NB));
        b2b_mode = 1'b0;

        // Abort at idx 3 while offering a new operand
        send(8'h6C, 8'h13, 1'b0);
        in_valid = 1'b0;
        wait_idx(3);
        flush_ok = 1'b1;
        abort    = 1'b1;
        in_valid = 1'b1;
        in_a     = 8'hEE;
        in_b     = 8'h11;
        #1 check("abort_ready", 32'(in_ready), 0);
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_valid", 32'(ser_valid), 0);
        check("abort_outs", 32'({ser_first, ser_last, ser_a, ser_b, ser_sub, ser_idx}), 0);
        check("abort_ready_after", 32'(in_ready), 1);
        @(negedge clk);
        #1 flush_ok = 1'b0;
        @(negedge clk);
        send(8'h21, 8'h43, 1'b1);
        in_valid = 1'b0;
        wait_done();

        // Asynchronous reset mid-operation
        send(8'h5B, 8'h27, 1'b0);
        in_valid = 1'b0;
        wait_idx(5);
        flush_ok = 1'b1;
        #2 aclr_n = 1'b0;
        #1;
        check("arst_outs", 32'({ser_valid, ser_first, ser_last, ser_a, ser_b, ser_sub, ser_idx}), 0);
        check("arst_ready", 32'(in_ready), 0);
        @(negedge clk);
        #3 aclr_n = 1'b1;
        #1 check("arst_rel_ready", 32'(in_ready), 1);
        @(negedge clk);
        #1 flush_ok = 1'b0;
        @(negedge clk);
        send(8'hFF, 8'h01, 1'b0);
        in_valid = 1'b0;
        wait_done();
        check("t5_sum", 32'(last_sum & 9'h0FF), 32'h000);

        // Overflow case: guard bit keeps the true sign
        send(8'h7F, 8'h01, 1'b0);
        in_valid = 1'b0;
        wait_done();
        check("t6_sum", 32'(last_sum), 32'h080);

        // Random operands with idle gaps
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), 8'($urandom), 1'($urandom));
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire
